img_mem_arbiter: RTL
====================

Name: img_mem_arbiter

Overview:
Two-requester arbiter sharing one single-port 64K x 8 image SRAM. Requester 0 is the gradient engine, which reads pixels. Requester 1 is the host loader/checker, which reads or writes. The arbiter owns the SRAM command pins (img_rd/img_wr/img_addr/img_do), routes read data back to the requester that issued the read, and enforces round-robin fairness with a bounded burst length.

Parameters:
AW, 16, address width (256x256 frame)
DW, 8, data width
MAX_BURST, 16, max consecutive grants to one requester while the other is waiting (1..255)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
r0_req  in  1  requester 0 command request
r0_wr  in  1  1 = write, 0 = read
r0_addr  in  AW  command address
r0_wdata  in  DW  write data
r0_gnt  out  1  command accepted this cycle (combinational)
r0_rvalid  out  1  r0_rdata valid
r0_rdata  out  DW  read return data
r1_req, r1_wr, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  same as r0_*, for requester 1
img_rd  out  1  SRAM read strobe (registered)
img_wr  out  1  SRAM write strobe (registered)
img_addr  out  AW  SRAM address (registered)
img_do  out  DW  SRAM write data (registered)
img_di  in  DW  SRAM read data, valid the cycle after img_rd

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: img_rd=0, img_wr=0, img_addr=0, img_do=0, r0_rvalid=0, r1_rvalid=0.
- Reset state: FSM=IDLE, burst_cnt=0, rr_last=1 (requester 0 wins the first tie).
- Reset mid-operation: in-flight read tags are cleared, so no rvalid is produced for reads issued before reset.
- Request rules:
  - A requester holds req, wr, addr and wdata stable until it sees gnt in the same cycle.
  - Exactly one gnt per cycle at most.
  - gnt depends only on req inputs and registered state.
- FSM states:
  - IDLE: no owner.
    - If only one requester asserts req, grant it and go to OWNx.
    - If both assert req, grant the requester != rr_last.
    - burst_cnt is set to 1 on entry to OWNx.
  - OWNx, owner requesting:
    - If the other requester is idle, grant the owner, stay in OWNx, burst_cnt saturates at MAX_BURST.
    - If the other requester is also requesting and burst_cnt < MAX_BURST, grant the owner and increment burst_cnt.
    - If the other requester is also requesting and burst_cnt == MAX_BURST, grant the other requester in that same cycle, go to OWNother, burst_cnt=1.
  - OWNx, owner not requesting:
    - If the other requester asserts req, grant it this cycle, go to OWNother, burst_cnt=1.
    - Otherwise go to IDLE.
  - rr_last is updated to the granted index on every grant.
- Timing:
  - Grant in cycle N → img_rd or img_wr, img_addr and img_do are driven in N+1 (one pulse per grant).
  - No grant → both strobes are 0 in N+1, and address and data hold their previous values.
- Read return:
  - A 2-stage tag pipeline records {valid, requester} per grant.
  - rX_rvalid=1 in cycle N+2 for a read granted in N. rX_rdata = img_di (combinational pass-through).
  - Writes produce no rvalid.
  - Back-to-back reads are fully pipelined: 1 read per cycle throughput, in-order return.
- Ordering: commands reach the SRAM in grant order. A write followed by a read to the same address (either requester) returns the new data.
- Arithmetic: burst_cnt width is clog2(MAX_BURST+1) and never wraps.

Decomposition:
- Shared package img_mem_pkg:
  - IMG_AW=16, IMG_DW=8
  - state encoding IDLE/OWN0/OWN1
  - typedef for the read-tag struct {valid, id}
- One natural sub-module: img_rr_sel. It takes the two req bits, state, burst_cnt and rr_last, and produces gnt[1:0], the next state and the next burst_cnt.
- The tag pipeline and command register stay in the top module.

Test Plan:
- Single read: after reset, r0_req=1, r0_wr=0, r0_addr=16'h0102 for one cycle (gnt=1) → next cycle img_rd=1, img_addr=16'h0102; SRAM returns 8'h5A → r0_rvalid=1, r0_rdata=8'h5A two cycles after grant, r1_rvalid=0 throughout.
- Tie after reset: r0 and r1 both request in the same first cycle → r0_gnt=1, r1_gnt=0 that cycle; with r0 then dropping req, r1_gnt=1 next cycle.
- Burst limit, MAX_BURST=4: both request continuously with incrementing addresses → grant pattern r0 x4, r1 x4, r0 x4…; img_rd pulses every cycle with no bubbles; each rvalid routed to the correct requester in order.
- Write-then-read: r1 writes 8'hC3 to 16'hFFFF, then reads 16'hFFFF → img_wr then img_rd on consecutive cycles; r1_rdata=8'hC3 with r1_rvalid two cycles after the read grant.
- Reset mid-read: r0 read granted in cycle N, reset asserted in N+1 → r0_rvalid stays 0 in N+2, img_rd=0 and img_addr=0 after reset, and the first post-reset tie again goes to r0.
- Owner drop: OWN0 with burst_cnt=2, r0_req falls while r1_req=1 → r1_gnt=1 that same cycle, state OWN1, burst_cnt=1.

Source files
------------

// File: rtl/img_mem_pkg.sv
// Shared widths, FSM encoding and read-tag type for the image SRAM arbiter.
// No logic, so there is no latency or backpressure of its own.
// The tag records which requester owns a read that is in flight.
package img_mem_pkg;

    localparam int IMG_AW = 16;
    localparam int IMG_DW = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

    function automatic logic [1:0] own_state(input logic id);
        return id ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/img_rr_sel.sv
// Round-robin grant selector with a bounded burst for two requesters.
// Purely combinational: grant, next state and next burst count settle in the same cycle.
// Backpressure is a withheld grant; the loser keeps its request up until granted.
module img_rr_sel
    import img_mem_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic [1:0]    req_i,
    input  logic [1:0]    state_i,
    input  logic [CW-1:0] burst_cnt_i,
    input  logic          rr_last_i,
    output logic [1:0]    gnt_o,
    output logic [1:0]    state_d_o,
    output logic [CW-1:0] burst_cnt_d_o
);

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic owner;
    logic other;
    logic win;

    always_comb begin
        gnt_o         = 2'b00;
        state_d_o     = state_i;
        burst_cnt_d_o = burst_cnt_i;
        owner         = (state_i == ST_OWN1);
        other         = ~owner;
        win           = 1'b0;

        case (state_i)
            ST_OWN0, ST_OWN1: begin
                if (req_i[owner]) begin
                    if (req_i[other] && (burst_cnt_i >= CNT_MAX)) begin
                        // Burst exhausted with the other side waiting: hand over now.
                        gnt_o[other]  = 1'b1;
                        state_d_o     = own_state(other);
                        burst_cnt_d_o = CNT_ONE;
                    end else begin
                        gnt_o[owner] = 1'b1;
                        if (burst_cnt_i < CNT_MAX) begin
                            burst_cnt_d_o = burst_cnt_i + CNT_ONE;
                        end
                    end
                end else if (req_i[other]) begin
                    gnt_o[other]  = 1'b1;
                    state_d_o     = own_state(other);
                    burst_cnt_d_o = CNT_ONE;
                end else begin
                    state_d_o     = ST_IDLE;
                    burst_cnt_d_o = '0;
                end
            end
            default: begin
                // Also recovers the unused encoding back to IDLE.
                win = (req_i[0] && req_i[1]) ? ~rr_last_i : req_i[1];
                if (|req_i) begin
                    gnt_o[win]    = 1'b1;
                    state_d_o     = own_state(win);
                    burst_cnt_d_o = CNT_ONE;
                end else begin
                    state_d_o     = ST_IDLE;
                    burst_cnt_d_o = '0;
                end
            end
        endcase
    end

endmodule

// File: rtl/img_mem_arbiter.sv
// Two-requester arbiter for one single-port image SRAM with tagged read return.
// Command hits the SRAM one cycle after grant; read data returns two cycles after grant.
// Backpressure is a withheld grant; no internal queueing, one command per cycle.
module img_mem_arbiter
    import img_mem_pkg::*;
#(
    parameter int AW        = IMG_AW,
    parameter int DW        = IMG_DW,
    parameter int MAX_BURST = 16
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          r0_req,
    input  logic          r0_wr,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,

    input  logic          r1_req,
    input  logic          r1_wr,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,

    output logic          img_rd,
    output logic          img_wr,
    output logic [AW-1:0] img_addr,
    output logic [DW-1:0] img_do,
    input  logic [DW-1:0] img_di
);

    localparam int CW = $clog2(MAX_BURST + 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] burst_q, burst_d;
    logic          rr_last_q, rr_last_d;

    logic [1:0]    req;
    logic [1:0]    gnt_sel;
    logic [1:0]    gnt;
    logic          gnt_any;

    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;

    logic          img_rd_q, img_rd_d;
    logic          img_wr_q, img_wr_d;
    logic [AW-1:0] img_addr_q, img_addr_d;
    logic [DW-1:0] img_do_q, img_do_d;

    rd_tag_t       tag0_q, tag0_d;
    rd_tag_t       tag1_q;

    assign req = {r1_req, r0_req};

    img_rr_sel #(
        .MAX_BURST (MAX_BURST),
        .CW        (CW)
    ) u_sel (
        .req_i         (req),
        .state_i       (state_q),
        .burst_cnt_i   (burst_q),
        .rr_last_i     (rr_last_q),
        .gnt_o         (gnt_sel),
        .state_d_o     (state_d),
        .burst_cnt_d_o (burst_d)
    );

    // A grant during reset would be dropped by the cleared command register.
    assign gnt     = reset ? 2'b00 : gnt_sel;
    assign gnt_any = |gnt;
    assign r0_gnt  = gnt[0];
    assign r1_gnt  = gnt[1];

    assign cmd_wr    = gnt[1] ? r1_wr    : r0_wr;
    assign cmd_addr  = gnt[1] ? r1_addr  : r0_addr;
    assign cmd_wdata = gnt[1] ? r1_wdata : r0_wdata;

    always_comb begin
        rr_last_d    = gnt_any ? gnt[1] : rr_last_q;
        img_rd_d     = gnt_any & ~cmd_wr;
        img_wr_d     = gnt_any & cmd_wr;
        img_addr_d   = gnt_any ? cmd_addr  : img_addr_q;
        img_do_d     = gnt_any ? cmd_wdata : img_do_q;
        tag0_d.valid = gnt_any & ~cmd_wr;
        tag0_d.id    = gnt[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            burst_q    <= '0;
            rr_last_q  <= 1'b1;
            img_rd_q   <= 1'b0;
            img_wr_q   <= 1'b0;
            img_addr_q <= '0;
            img_do_q   <= '0;
            tag0_q     <= '0;
            tag1_q     <= '0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            rr_last_q  <= rr_last_d;
            img_rd_q   <= img_rd_d;
            img_wr_q   <= img_wr_d;
            img_addr_q <= img_addr_d;
            img_do_q   <= img_do_d;
            tag0_q     <= tag0_d;
            tag1_q     <= tag0_q;
        end
    end

    assign img_rd   = img_rd_q;
    assign img_wr   = img_wr_q;
    assign img_addr = img_addr_q;
    assign img_do   = img_do_q;

    // Second tag stage lines up with SRAM data, which lands a cycle after the strobe.
    assign r0_rvalid = tag1_q.valid & ~tag1_q.id;
    assign r1_rvalid = tag1_q.valid &  tag1_q.id;
    assign r0_rdata  = img_di;
    assign r1_rdata  = img_di;

endmodule
